// File: rtl/alu_addsub_seq.sv
// alu_addsub_seq: multi-cycle add/subtract unit. The operand pair is consumed
// SLICE bits per clock, LSB slice first, and the unit reports the per-bit
// carry chain, the propagate vector and 8085-style flags.
// Optional feature macro: ALU_BCD_EN adds per-nibble decimal adjust for
// additions with iDec=1 (requires SLICE=4). Without it iDec is ignored.
//
// state | meaning
// IDLE  | waiting for iStart, results from the last operation held
// RUN   | one slice of the operands added per cycle
// DONE  | one-cycle oDone pulse, flags valid; iStart here chains a new run
module alu_addsub_seq #(
    parameter int DATASIZE = 16,
    parameter int SLICE    = 4
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic                iSub,
    input  logic                iDec,
    input  logic [DATASIZE-1:0] iA,
    input  logic [DATASIZE-1:0] iB,
    input  logic                iC,
    output logic                oBusy,
    output logic                oDone,
    output logic [DATASIZE-1:0] oS,
    output logic [DATASIZE-1:0] oC,
    output logic [DATASIZE-1:0] oP,
    output logic                oCarry,
    output logic                oAux,
    output logic                oZero,
    output logic                oParity,
    output logic                oSign
);

    localparam int NSLICE  = DATASIZE / SLICE;
    localparam int IW      = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int AUX_BIT = (DATASIZE > 3) ? 3 : DATASIZE - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATASIZE-1:0] a_q;
    logic [DATASIZE-1:0] b_q;       // B already inverted for subtract
    logic                carry_q;   // running carry between slices
    logic                sub_q;
    logic [IW-1:0]       idx_q;
    logic                busy_q;
    logic                done_q;
    logic [DATASIZE-1:0] s_q;
    logic [DATASIZE-1:0] c_q;
    logic [DATASIZE-1:0] p_q;
    logic                carry_flag_q;
    logic                aux_q;
    logic                zero_q;
    logic                parity_q;
    logic                sign_q;

`ifdef ALU_BCD_EN
    logic                dec_q;     // decimal adjust active for this run
`else
    logic                unused_dec;
    assign unused_dec = iDec;
`endif

    logic [SLICE-1:0]    a_sl;
    logic [SLICE-1:0]    b_sl;
    logic [SLICE-1:0]    sum_sl;
    logic [SLICE-1:0]    cvec_sl;
    logic [SLICE-1:0]    res_sl;
    logic                cout_sl;
    logic                cc;
    logic [SLICE:0]      bin_w;
    logic [DATASIZE-1:0] s_d;
    logic [DATASIZE-1:0] c_d;
    logic [DATASIZE-1:0] p_d;

    // Add the currently selected slice and merge it into the result vectors.
    always_comb begin
        a_sl    = '0;
        b_sl    = '0;
        sum_sl  = '0;
        cvec_sl = '0;
        bin_w   = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IW'(k)) begin
                a_sl = a_q[k*SLICE +: SLICE];
                b_sl = b_q[k*SLICE +: SLICE];
            end
        end
        cc = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            sum_sl[i]  = a_sl[i] ^ b_sl[i] ^ cc;
            cc         = (a_sl[i] & b_sl[i]) | (cc & (a_sl[i] ^ b_sl[i]));
            cvec_sl[i] = cc;
        end
        res_sl  = sum_sl;
        cout_sl = cc;
`ifdef ALU_BCD_EN
        // Decimal adjust: a nibble above 9 (or one that carried) gets +6,
        // and the decimal carry replaces the binary one for the next slice.
        if (dec_q) begin
            bin_w = {cc, sum_sl};
            if (bin_w > (SLICE+1)'(9)) begin
                bin_w   = bin_w + (SLICE+1)'(6);
                res_sl  = bin_w[SLICE-1:0];
                cout_sl = 1'b1;
            end
        end
`endif
        s_d = s_q;
        c_d = c_q;
        p_d = p_q;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IW'(k)) begin
                s_d[k*SLICE +: SLICE] = res_sl;
                c_d[k*SLICE +: SLICE] = cvec_sl;
                p_d[k*SLICE +: SLICE] = a_sl ^ b_sl;
            end
        end
    end

    // Sequencer: operand capture, one slice per RUN cycle, flag registration.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            sub_q        <= 1'b0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s_q          <= '0;
            c_q          <= '0;
            p_q          <= '0;
            carry_flag_q <= 1'b0;
            aux_q        <= 1'b0;
            zero_q       <= 1'b0;
            parity_q     <= 1'b0;
            sign_q       <= 1'b0;
`ifdef ALU_BCD_EN
            dec_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (iStart) begin
                        a_q          <= iA;
                        b_q          <= iSub ? ~iB : iB;
                        carry_q      <= iSub ? ~iC : iC;
                        sub_q        <= iSub;
`ifdef ALU_BCD_EN
                        dec_q        <= iDec & ~iSub;
`endif
                        idx_q        <= '0;
                        s_q          <= '0;
                        c_q          <= '0;
                        p_q          <= '0;
                        carry_flag_q <= 1'b0;
                        aux_q        <= 1'b0;
                        zero_q       <= 1'b0;
                        parity_q     <= 1'b0;
                        sign_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    c_q     <= c_d;
                    p_q     <= p_d;
                    carry_q <= cout_sl;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == IW'(NSLICE - 1)) begin
                        carry_flag_q <= cout_sl ^ sub_q;
                        aux_q        <= c_d[AUX_BIT];
                        zero_q       <= (s_d == '0);
                        parity_q     <= ~^s_d;
                        sign_q       <= s_d[DATASIZE-1];
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oS      = s_q;
    assign oC      = c_q;
    assign oP      = p_q;
    assign oCarry  = carry_flag_q;
    assign oAux    = aux_q;
    assign oZero   = zero_q;
    assign oParity = parity_q;
    assign oSign   = sign_q;

endmodule
